// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipeline: widths, opcode field, bubble
// encoding and the halt-controller state type.
package cpu_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  localparam logic [3:0]         OP_HLT    = 4'hF;
  // ADD R0,R0,R0 with R0 hardwired to zero: architecturally a no-op
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HLT_ID = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } halt_state_e;

  function automatic logic [3:0] opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bus between the fetch stage and the rest of the pipeline (hazard unit,
// EX redirect, instruction memory, IF/ID consumer). IF_PERF_CNT_EN adds counters.
interface if_stage_if;
  import cpu_pkg::*;

  logic               stall;
  logic               flush;
  logic [PC_W-1:0]    target_pc;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr_IF_ID;
  logic [PC_W-1:0]    pc_IF_ID;
  logic               valid_IF_ID;
  logic               hlt;
`ifdef IF_PERF_CNT_EN
  logic [15:0]        stall_cnt;
  logic [15:0]        flush_cnt;

  modport master (
    input  stall, flush, target_pc, imem_rdata,
    output imem_addr, instr_IF_ID, pc_IF_ID, valid_IF_ID, hlt, stall_cnt, flush_cnt
  );
  modport slave (
    output stall, flush, target_pc, imem_rdata,
    input  imem_addr, instr_IF_ID, pc_IF_ID, valid_IF_ID, hlt, stall_cnt, flush_cnt
  );
`else
  modport master (
    input  stall, flush, target_pc, imem_rdata,
    output imem_addr, instr_IF_ID, pc_IF_ID, valid_IF_ID, hlt
  );
  modport slave (
    output stall, flush, target_pc, imem_rdata,
    input  imem_addr, instr_IF_ID, pc_IF_ID, valid_IF_ID, hlt
  );
`endif

endinterface

// File: rtl/if_halt_ctrl.sv
// Halt controller: stops fetch when HLT is fetched, drains the pipeline for
// DRAIN_CYCLES non-stalled cycles, then raises hlt until reset.
module if_halt_ctrl
  import cpu_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall,
  input  logic flush,
  input  logic is_hlt,
  output logic pc_hold,
  output logic force_bubble,
  output logic hlt
);

  localparam int CNT_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  halt_state_e      state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             bubble_reg;
  logic             hlt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= RUN;
      cnt_reg    <= '0;
      bubble_reg <= 1'b0;
      hlt_reg    <= 1'b0;
    end else if (state_reg != HALTED) begin
      if (flush) begin
        // an older taken branch abandons any pending halt
        state_reg  <= RUN;
        cnt_reg    <= '0;
        bubble_reg <= 1'b0;
      end else if (!stall) begin
        case (state_reg)
          RUN: begin
            if (is_hlt) begin
              state_reg  <= HLT_ID;
              bubble_reg <= 1'b1;
            end
          end
          HLT_ID: begin
            state_reg <= DRAIN;
            cnt_reg   <= CNT_W'(1);
          end
          DRAIN: begin
            if (cnt_reg == CNT_W'(DRAIN_CYCLES)) begin
              state_reg <= HALTED;
              hlt_reg   <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // outside RUN the bubble flag is already set, so is_hlt only matters in RUN
  assign pc_hold      = bubble_reg | is_hlt;
  assign force_bubble = bubble_reg;
  assign hlt          = hlt_reg;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, combinational imem address and the
// IF/ID pipeline register. Optional IF_PERF_CNT_EN adds stall/flush counters.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int              DRAIN_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  if_stage_if.master    bus
);

  logic [PC_W-1:0]    pc_reg;
  logic [PC_W-1:0]    pc_inc;
  logic [INSTR_W-1:0] instr_reg;
  logic [PC_W-1:0]    pc_ifid_reg;
  logic               valid_reg;
  logic               is_hlt;
  logic               pc_hold;
  logic               force_bubble;
  logic               hlt;

  assign pc_inc = pc_reg + PC_W'(1);
  assign is_hlt = (opcode(bus.imem_rdata) == OP_HLT);

  if_halt_ctrl #(
    .DRAIN_CYCLES (DRAIN_CYCLES)
  ) u_halt_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (bus.stall),
    .flush        (bus.flush),
    .is_hlt       (is_hlt),
    .pc_hold      (pc_hold),
    .force_bubble (force_bubble),
    .hlt          (hlt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg      <= RESET_PC;
      instr_reg   <= NOP_INSTR;
      pc_ifid_reg <= '0;
      valid_reg   <= 1'b0;
    end else if (hlt) begin
      // halted: everything frozen, stall and flush ignored
    end else if (bus.flush) begin
      pc_reg      <= bus.target_pc;
      instr_reg   <= NOP_INSTR;
      pc_ifid_reg <= '0;
      valid_reg   <= 1'b0;
    end else if (!bus.stall) begin
      if (force_bubble) begin
        instr_reg   <= NOP_INSTR;
        pc_ifid_reg <= '0;
        valid_reg   <= 1'b0;
      end else begin
        instr_reg   <= bus.imem_rdata;
        pc_ifid_reg <= pc_inc;
        valid_reg   <= 1'b1;
        if (!pc_hold) begin
          pc_reg <= pc_inc;
        end
      end
    end
  end

  assign bus.imem_addr   = pc_reg;
  assign bus.instr_IF_ID = instr_reg;
  assign bus.pc_IF_ID    = pc_ifid_reg;
  assign bus.valid_IF_ID = valid_reg;
  assign bus.hlt         = hlt;

`ifdef IF_PERF_CNT_EN
  logic [15:0] stall_cnt_reg;
  logic [15:0] flush_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else if (!hlt) begin
      if (bus.flush) begin
        if (flush_cnt_reg != 16'hFFFF) flush_cnt_reg <= flush_cnt_reg + 16'd1;
      end else if (bus.stall) begin
        if (stall_cnt_reg != 16'hFFFF) stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
    end
  end

  assign bus.stall_cnt = stall_cnt_reg;
  assign bus.flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed steps push the expected post-edge
// state, an independent monitor pops and compares after each rising edge.
module tb_if_stage;
  import cpu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_stage_if bus ();

  if_stage #(
    .RESET_PC     (16'h0000),
    .DRAIN_CYCLES (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] pcid;
    logic        valid;
    logic        hlt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input string field,
                     input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s %s: got %h required %h", tag, field, got, want);
    end
  endtask

  // monitor: one expected entry per edge, compared #1 after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        $display("%-14s addr=%h instr=%h pc_ifid=%h valid=%b hlt=%b", e.tag,
                 bus.imem_addr, bus.instr_IF_ID, bus.pc_IF_ID, bus.valid_IF_ID, bus.hlt);
        chk(e.tag, "imem_addr",   bus.imem_addr,             e.pc);
        chk(e.tag, "instr_IF_ID", bus.instr_IF_ID,           e.instr);
        chk(e.tag, "pc_IF_ID",    bus.pc_IF_ID,              e.pcid);
        chk(e.tag, "valid_IF_ID", {15'd0, bus.valid_IF_ID},  {15'd0, e.valid});
        chk(e.tag, "hlt",         {15'd0, bus.hlt},          {15'd0, e.hlt});
      end
    end
  end

  // drive inputs at the falling edge and record what the next rising edge must produce
  task automatic step(input string tag, input logic rn, input logic st, input logic fl,
                      input logic [15:0] tgt, input logic [15:0] rd,
                      input logic [15:0] e_pc, input logic [15:0] e_instr,
                      input logic [15:0] e_pcid, input logic e_val, input logic e_hlt);
    exp_t e;
    @(negedge clk);
    rst_n          = rn;
    bus.stall      = st;
    bus.flush      = fl;
    bus.target_pc  = tgt;
    bus.imem_rdata = rd;
    e.tag   = tag;
    e.pc    = e_pc;
    e.instr = e_instr;
    e.pcid  = e_pcid;
    e.valid = e_val;
    e.hlt   = e_hlt;
    sb_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.stall      = 1'b0;
    bus.flush      = 1'b0;
    bus.target_pc  = 16'h0000;
    bus.imem_rdata = 16'h0000;

    //    tag              rn st fl tgt      rdata    pc       instr    pcid     v  h
    step("reset_noisy",    0, 1, 1, 16'h0055, 16'hF000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    step("reset",          0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    step("fetch_0",        1, 0, 0, 16'h0000, 16'h1123, 16'h0001, 16'h1123, 16'h0001, 1, 0);
    step("fetch_1",        1, 0, 0, 16'h0000, 16'h2456, 16'h0002, 16'h2456, 16'h0002, 1, 0);
    step("fetch_2",        1, 0, 0, 16'h0000, 16'h3789, 16'h0003, 16'h3789, 16'h0003, 1, 0);
    step("fetch_3",        1, 0, 0, 16'h0000, 16'h4000, 16'h0004, 16'h4000, 16'h0004, 1, 0);
    step("fetch_4",        1, 0, 0, 16'h0000, 16'h4001, 16'h0005, 16'h4001, 16'h0005, 1, 0);
    step("stall_a",        1, 1, 0, 16'h0000, 16'h5555, 16'h0005, 16'h4001, 16'h0005, 1, 0);
    step("stall_b",        1, 1, 0, 16'h0000, 16'h5556, 16'h0005, 16'h4001, 16'h0005, 1, 0);
    step("resume_5",       1, 0, 0, 16'h0000, 16'h4002, 16'h0006, 16'h4002, 16'h0006, 1, 0);
    step("flush_stall",    1, 1, 1, 16'h0040, 16'h7777, 16'h0040, 16'h0000, 16'h0000, 0, 0);
    step("fetch_40",       1, 0, 0, 16'h0000, 16'h1234, 16'h0041, 16'h1234, 16'h0041, 1, 0);
    step("flush_ffff",     1, 0, 1, 16'hFFFF, 16'h1111, 16'hFFFF, 16'h0000, 16'h0000, 0, 0);
    step("wrap",           1, 0, 0, 16'h0000, 16'h2222, 16'h0000, 16'h2222, 16'h0000, 1, 0);
    step("after_wrap",     1, 0, 0, 16'h0000, 16'h3333, 16'h0001, 16'h3333, 16'h0001, 1, 0);
    // halt at PC 8 with a 2-cycle stall inside the drain
    step("flush_8",        1, 0, 1, 16'h0008, 16'h3333, 16'h0008, 16'h0000, 16'h0000, 0, 0);
    step("hlt_fetch",      1, 0, 0, 16'h0000, 16'hF000, 16'h0008, 16'hF000, 16'h0009, 1, 0);
    step("hlt_bubble",     1, 0, 0, 16'h0000, 16'h1111, 16'h0008, 16'h0000, 16'h0000, 0, 0);
    step("drain_2",        1, 0, 0, 16'h0000, 16'h1111, 16'h0008, 16'h0000, 16'h0000, 0, 0);
    step("drain_stall_a",  1, 1, 0, 16'h0000, 16'h1111, 16'h0008, 16'h0000, 16'h0000, 0, 0);
    step("drain_stall_b",  1, 1, 0, 16'h0000, 16'h1111, 16'h0008, 16'h0000, 16'h0000, 0, 0);
    step("drain_3",        1, 0, 0, 16'h0000, 16'h1111, 16'h0008, 16'h0000, 16'h0000, 0, 0);
    step("drain_4",        1, 0, 0, 16'h0000, 16'h1111, 16'h0008, 16'h0000, 16'h0000, 0, 0);
    step("halted",         1, 0, 0, 16'h0000, 16'h1111, 16'h0008, 16'h0000, 16'h0000, 0, 1);
    step("halt_flush",     1, 0, 1, 16'h0099, 16'h1111, 16'h0008, 16'h0000, 16'h0000, 0, 1);
    step("halt_flush_st",  1, 1, 1, 16'h0077, 16'h1000, 16'h0008, 16'h0000, 16'h0000, 0, 1);
    step("halt_free",      1, 0, 0, 16'h0000, 16'h1000, 16'h0008, 16'h0000, 16'h0000, 0, 1);
    step("reset_halted",   0, 0, 0, 16'h0000, 16'h1000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    step("post_rst_fetch", 1, 0, 0, 16'h0000, 16'h1123, 16'h0001, 16'h1123, 16'h0001, 1, 0);
    // halt abandoned by a flush during the drain
    step("flush_10",       1, 0, 1, 16'h0010, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 0, 0);
    step("hlt_fetch2",     1, 0, 0, 16'h0000, 16'hF123, 16'h0010, 16'hF123, 16'h0011, 1, 0);
    step("hlt_bubble2",    1, 0, 0, 16'h0000, 16'h5000, 16'h0010, 16'h0000, 16'h0000, 0, 0);
    step("drain2_2",       1, 0, 0, 16'h0000, 16'h5000, 16'h0010, 16'h0000, 16'h0000, 0, 0);
    step("drain_flush",    1, 0, 1, 16'h0020, 16'h5000, 16'h0020, 16'h0000, 16'h0000, 0, 0);
    step("run_20",         1, 0, 0, 16'h0000, 16'h2345, 16'h0021, 16'h2345, 16'h0021, 1, 0);
    step("run_21",         1, 0, 0, 16'h0000, 16'h3456, 16'h0022, 16'h3456, 16'h0022, 1, 0);
    step("run_22",         1, 0, 0, 16'h0000, 16'h3457, 16'h0023, 16'h3457, 16'h0023, 1, 0);
    step("run_23",         1, 0, 0, 16'h0000, 16'h3458, 16'h0024, 16'h3458, 16'h0024, 1, 0);
    step("run_24",         1, 0, 0, 16'h0000, 16'h3459, 16'h0025, 16'h3459, 16'h0025, 1, 0);
    // reset in the middle of a drain
    step("hlt_fetch3",     1, 0, 0, 16'h0000, 16'hF000, 16'h0025, 16'hF000, 16'h0026, 1, 0);
    step("hlt_bubble3",    1, 0, 0, 16'h0000, 16'h0000, 16'h0025, 16'h0000, 16'h0000, 0, 0);
    step("drain3_2",       1, 0, 0, 16'h0000, 16'h0000, 16'h0025, 16'h0000, 16'h0000, 0, 0);
    step("reset_drain",    0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    step("post_rst_a",     1, 0, 0, 16'h0000, 16'h1123, 16'h0001, 16'h1123, 16'h0001, 1, 0);
    step("post_rst_b",     1, 0, 0, 16'h0000, 16'h2456, 16'h0002, 16'h2456, 16'h0002, 1, 0);
    step("post_rst_c",     1, 0, 0, 16'h0000, 16'h3789, 16'h0003, 16'h3789, 16'h0003, 1, 0);
    step("post_rst_d",     1, 0, 0, 16'h0000, 16'h0789, 16'h0004, 16'h0789, 16'h0004, 1, 0);
    step("post_rst_e",     1, 0, 0, 16'h0000, 16'h0790, 16'h0005, 16'h0790, 16'h0005, 1, 0);
    step("post_rst_f",     1, 0, 0, 16'h0000, 16'h0791, 16'h0006, 16'h0791, 16'h0006, 1, 0);

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries required 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
